// File: rtl/coeff_collect_pkg.sv
// Shared definitions for the coefficient stream: word geometry, fill FSM encoding,
// and the MSB-first bank slice helper used by both source and collector.
package coeff_collect_pkg;

    localparam int NBITS_DEF = 2;
    localparam int N_DEF     = 8;
    localparam int W         = 2 * NBITS_DEF;
    localparam int IDX_W     = $clog2(N_DEF);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_t;

    function automatic int word_width(input int nbits);
        return 2 * nbits;
    endfunction

    // LSB position of word k in an n-word bank; word 0 occupies the MSBs.
    function automatic int word_lsb(input int k, input int n, input int w);
        return (n - 1 - k) * w;
    endfunction

endpackage

// File: rtl/coeff_fill_buf.sv
// N x W register file: one indexed write port, whole contents visible as a flat
// MSB-first bank.
module coeff_fill_buf
    import coeff_collect_pkg::*;
#(
    parameter int N     = 8,
    parameter int W     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [IDX_W-1:0]   widx,
    input  logic [W-1:0]       wdata,
    output logic [N*W-1:0]     rdata
);

    logic [W-1:0] mem [N];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem <= '{default: '0};
        end else if (we) begin
            mem[widx] <= wdata;
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_rd
        assign rdata[word_lsb(k, N, W) +: W] = mem[k];
    end

endmodule

// File: rtl/coeff_collect.sv
// Collects the serial twiddle-coefficient stream into N-word frames and publishes
// each complete frame as a held parallel bank for the butterfly datapath.
module coeff_collect
    import coeff_collect_pkg::*;
#(
    parameter int NBITS = 2,
    parameter int N     = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2*NBITS-1:0]      coeff_in,
    input  logic                    coeff_valid,
    input  logic                    coeff_sof,
    output logic [N*2*NBITS-1:0]    bank_out,
    output logic                    bank_valid,
    input  logic                    bank_ack,
    output logic                    overrun,
    output logic                    frame_err
);

    localparam int CW   = word_width(NBITS);
    localparam int IW   = $clog2(N);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    fill_state_t       state, state_nx;
    logic [IW-1:0]     idx, idx_nx;
    logic              wr_en;
    logic [IW-1:0]     wr_idx;
    logic              done_nx, err_nx;
    logic              done_q;
    logic [N*CW-1:0]   fill_bank;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        if (coeff_valid) begin
            if (coeff_sof) begin
                state_nx = FILL;
                idx_nx   = IW'(1);
            end else if (state == FILL) begin
                if (idx == LAST) begin
                    state_nx = IDLE;
                    idx_nx   = '0;
                end else begin
                    idx_nx = idx + IW'(1);
                end
            end
        end
    end

    // A sof always wins over completion, even when it lands on the last-word slot.
    always_comb begin
        wr_en   = coeff_valid && (coeff_sof || state == FILL);
        wr_idx  = coeff_sof ? '0 : idx;
        err_nx  = coeff_valid && coeff_sof && state == FILL;
        done_nx = coeff_valid && !coeff_sof && state == FILL && idx == LAST;
    end

    coeff_fill_buf #(
        .N     (N),
        .W     (CW),
        .IDX_W (IW)
    ) u_fill (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_en),
        .widx  (wr_idx),
        .wdata (coeff_in),
        .rdata (fill_bank)
    );

    // Publish one edge after completion; an ack in that cycle frees the slot for it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q     <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            bank_valid <= 1'b0;
            bank_out   <= '0;
        end else begin
            done_q    <= done_nx;
            frame_err <= err_nx;
            overrun   <= done_q && bank_valid && !bank_ack;
            if (done_q && (!bank_valid || bank_ack)) begin
                bank_out   <= fill_bank;
                bank_valid <= 1'b1;
            end else if (bank_valid && bank_ack) begin
                bank_valid <= 1'b0;
            end
        end
    end

endmodule
